round_timer_ctrl: RTL and testbench
===================================

Name: round_timer_ctrl

Overview:
- Parametrised round sequencer for the door-guessing game. Replaces the hand-wired timer/pause/lives glue in the top level.
- Generates the per-second tick and counts the round down. It freezes player choices at time-up, holds a reveal pause, then decrements lives for wrong guesses.
- Detects game over for N players.
- Sits between the switch/position inputs and screen_drawer / seven-segment drivers, in the VGA_CLK domain.

Parameters:
- NUM_PLAYERS, 2, number of players (1..8)
- CLK_HZ, 25_000_000, clk cycles per second tick
- ROUND_SEC, 5, round length in seconds (1..2^TIME_W-1)
- PAUSE_SEC, 1, reveal pause length in seconds (>=1)
- LIVES, 3, starting lives per player (1..2^LIFE_W-1)
- TIME_W, 4, width of the seconds counter
- LIFE_W, 2, width of each lives field
- POS_W, 2, width of each door/position field
- END_ON_FIRST_OUT, 1, 1: game ends when any player reaches 0 lives; 0: game ends when <=1 player has lives

Ports:
- clk  in  1  system clock (VGA_CLK)
- reset  in  1  synchronous, active-high
- start  in  1  level; begins a game from IDLE or GAME_OVER
- player_pos  in  NUM_PLAYERS*POS_W  player i choice at [i*POS_W +: POS_W]
- correct_door  in  NUM_PLAYERS*POS_W  correct door per player, same packing
- seconds_left  out  TIME_W  remaining round seconds
- time_up  out  1  high throughout REVEAL
- resume  out  1  one-cycle pulse when REVEAL ends
- frozen_pos  out  NUM_PLAYERS*POS_W  choices latched at time-up
- lives  out  NUM_PLAYERS*LIFE_W  lives per player
- hit  out  NUM_PLAYERS  per-player correct-guess flags from the last evaluation
- game_over  out  1  high in GAME_OVER
- state  out  2  encoded FSM state, for LEDs/debug

Behaviour:
- States: IDLE=0, PLAY=1, REVEAL=2, GAME_OVER=3.

Reset:
- state=IDLE, seconds_left=ROUND_SEC, lives all =LIVES.
- time_up=0, resume=0, frozen_pos=0, hit=0, game_over=0.
- Prescaler is cleared.
- Reset wins over every other input, including mid-round and mid-reveal.

Tick generation:
- Prescaler counts 0..CLK_HZ-1 and pulses sec_tick on the terminal count.
- The prescaler is cleared on every state entry, so the first tick in a state arrives exactly CLK_HZ cycles after entry.

IDLE:
- seconds_left=ROUND_SEC.
- start=1 -> PLAY next cycle, with lives reloaded to LIVES and hit cleared.

PLAY:
- Each sec_tick decrements seconds_left.
- When seconds_left==1 and sec_tick occurs:
  - seconds_left goes to 0;
  - frozen_pos <= player_pos, sampled in that same cycle;
  - -> REVEAL.
- start is ignored in PLAY.

REVEAL:
- time_up=1. Pause counter counts sec_ticks up to PAUSE_SEC.
- player_pos changes are ignored.
- On the PAUSE_SEC-th tick, in one cycle:
  - hit[i] = (frozen_pos[i]==correct_door[i]);
  - lives[i] decrements if !hit[i] and lives[i]!=0 (saturating at 0, never wraps);
  - resume pulses for 1 cycle.
- Next state is computed from the post-decrement lives:
  - end condition met -> GAME_OVER;
  - otherwise -> PLAY with seconds_left=ROUND_SEC.

End condition:
- END_ON_FIRST_OUT=1: any lives[i]==0.
- END_ON_FIRST_OUT=0: count of nonzero lives <=1.
- Players with lives==0 are never decremented and never counted as hits.

GAME_OVER:
- game_over=1; lives, hit and frozen_pos hold.
- start=1 -> PLAY with lives reloaded, hit cleared, seconds_left=ROUND_SEC.

Latencies and width rules:
- Latency from time-up tick to time_up=1: 1 cycle (registered).
- resume rises in the same cycle the state leaves REVEAL.
- seconds_left never underflows.
- All counters size from $clog2 of their maximum value.

Decomposition:
- Package round_pkg:
  - state_t enum (IDLE, PLAY, REVEAL, GAME_OVER);
  - field-extract helpers for packed per-player vectors.
- One sub-module: sec_tick_gen #(CLK_HZ), with clk, reset, clear in, tick out. It replaces the ad-hoc counter used for the pause and the timer.
- Lives/hit update is a generate loop over NUM_PLAYERS inside round_timer_ctrl.

Test Plan (benches set CLK_HZ=10, ROUND_SEC=3, PAUSE_SEC=1, LIVES=2):
1. reset, start pulse -> PLAY; seconds_left steps 3,2,1,0, 10 cycles apart; time_up rises 1 cycle after the 0 tick; resume pulses exactly 10 cycles later.
2. Round with P0 pos=1/door=1, P1 pos=2/door=0 -> hit=2'b01, lives P0=2, P1=1, back to PLAY with seconds_left=3.
3. Change player_pos during REVEAL -> frozen_pos unchanged, hit result uses the values sampled at time-up.
4. END_ON_FIRST_OUT=1, P1 wrong twice -> P1 lives 0, game_over=1, state=3. Extra ticks do not change lives. start -> lives reload to 2,2.
5. NUM_PLAYERS=3, END_ON_FIRST_OUT=0, P2 eliminated first -> play continues. P2 lives stay 0 and are not decremented. Game ends when P1 also hits 0.
6. Assert reset mid-REVEAL -> next cycle state=0, time_up=0, lives=2, seconds_left=3; no resume pulse.

Source files
------------

// File: rtl/round_pkg.sv
// rtl/round_pkg.sv - shared state encoding and per-player field helpers for the round sequencer
package round_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PLAY      = 2'd1,
        S_REVEAL    = 2'd2,
        S_GAME_OVER = 2'd3
    } state_t;

    // Extracts field idx of width w (w <= 8) from a packed per-player vector.
    function automatic logic [7:0] get_field(input logic [63:0] vec, input int idx, input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return 8'((vec >> (idx * w)) & mask);
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// rtl/sec_tick_gen.sv - free-running prescaler producing a one-cycle tick every CLK_HZ cycles
module sec_tick_gen #(
    parameter int CLK_HZ = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (cnt == TERM) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Tick depends only on the count so the clear path never loops back into it.
    assign tick = (cnt == TERM);

endmodule

// File: rtl/round_timer_ctrl.sv
// rtl/round_timer_ctrl.sv - round countdown, reveal pause, lives bookkeeping and game-over detection
module round_timer_ctrl
    import round_pkg::*;
#(
    parameter int NUM_PLAYERS      = 2,
    parameter int CLK_HZ           = 25_000_000,
    parameter int ROUND_SEC        = 5,
    parameter int PAUSE_SEC        = 1,
    parameter int LIVES            = 3,
    parameter int TIME_W           = 4,
    parameter int LIFE_W           = 2,
    parameter int POS_W            = 2,
    parameter int END_ON_FIRST_OUT = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [NUM_PLAYERS*POS_W-1:0]  player_pos,
    input  logic [NUM_PLAYERS*POS_W-1:0]  correct_door,
    output logic [TIME_W-1:0]             seconds_left,
    output logic                          time_up,
    output logic                          resume,
    output logic [NUM_PLAYERS*POS_W-1:0]  frozen_pos,
    output logic [NUM_PLAYERS*LIFE_W-1:0] lives,
    output logic [NUM_PLAYERS-1:0]        hit,
    output logic                          game_over,
    output logic [1:0]                    state
);

    localparam logic [TIME_W-1:0] ROUND_V = TIME_W'(ROUND_SEC);
    localparam logic [LIFE_W-1:0] LIVES_V = LIFE_W'(LIVES);
    localparam int PAUSE_W = (PAUSE_SEC > 1) ? $clog2(PAUSE_SEC) : 1;
    localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_SEC - 1);

    state_t cur_state, nxt_state;
    logic   sec_tick, tick_clear, eval, end_cond;
    logic [PAUSE_W-1:0]            pause_cnt;
    logic [NUM_PLAYERS-1:0]        hit_eval, alive_post;
    logic [NUM_PLAYERS*LIFE_W-1:0] lives_eval;

    sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_sec_tick (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear),
        .tick  (sec_tick)
    );

    // Eliminated players neither score a hit nor lose further lives.
    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_player
        logic [LIFE_W-1:0] cur_l;
        logic [POS_W-1:0]  pos_f, door_f;
        assign cur_l  = LIFE_W'(get_field(64'(lives), i, LIFE_W));
        assign pos_f  = POS_W'(get_field(64'(frozen_pos), i, POS_W));
        assign door_f = POS_W'(get_field(64'(correct_door), i, POS_W));
        assign hit_eval[i] = (cur_l != '0) && (pos_f == door_f);
        assign lives_eval[i*LIFE_W +: LIFE_W] =
            ((cur_l != '0) && !hit_eval[i]) ? cur_l - LIFE_W'(1) : cur_l;
        assign alive_post[i] = (lives_eval[i*LIFE_W +: LIFE_W] != '0);
    end

    always_comb begin
        end_cond = 1'b0;
        if (END_ON_FIRST_OUT != 0) begin
            end_cond = ~&alive_post;
        end else begin
            end_cond = ($countones(alive_post) <= 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        eval      = 1'b0;
        case (cur_state)
            S_IDLE:      if (start) nxt_state = S_PLAY;
            S_PLAY:      if (sec_tick && seconds_left == TIME_W'(1)) nxt_state = S_REVEAL;
            S_REVEAL: begin
                if (sec_tick && pause_cnt == PAUSE_LAST) begin
                    eval      = 1'b1;
                    nxt_state = end_cond ? S_GAME_OVER : S_PLAY;
                end
            end
            S_GAME_OVER: if (start) nxt_state = S_PLAY;
            default:     nxt_state = S_IDLE;
        endcase
    end

    assign tick_clear = (nxt_state != cur_state);

    always_ff @(posedge clk) begin
        if (reset) begin
            seconds_left <= ROUND_V;
            lives        <= {NUM_PLAYERS{LIVES_V}};
            frozen_pos   <= '0;
            hit          <= '0;
            resume       <= 1'b0;
            pause_cnt    <= '0;
        end else begin
            resume <= eval;
            case (cur_state)
                S_IDLE: begin
                    seconds_left <= ROUND_V;
                    if (start) begin
                        lives <= {NUM_PLAYERS{LIVES_V}};
                        hit   <= '0;
                    end
                end
                S_PLAY: begin
                    pause_cnt <= '0;
                    if (sec_tick && seconds_left != '0) begin
                        seconds_left <= seconds_left - TIME_W'(1);
                        if (seconds_left == TIME_W'(1)) frozen_pos <= player_pos;
                    end
                end
                S_REVEAL: begin
                    if (eval) begin
                        hit   <= hit_eval;
                        lives <= lives_eval;
                        if (!end_cond) seconds_left <= ROUND_V;
                    end else if (sec_tick) begin
                        pause_cnt <= pause_cnt + PAUSE_W'(1);
                    end
                end
                S_GAME_OVER: begin
                    if (start) begin
                        lives        <= {NUM_PLAYERS{LIVES_V}};
                        hit          <= '0;
                        seconds_left <= ROUND_V;
                    end
                end
                default: ;
            endcase
        end
    end

    assign time_up   = (cur_state == S_REVEAL);
    assign game_over = (cur_state == S_GAME_OVER);
    assign state     = cur_state;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// tb/tb_round_timer_ctrl.sv - table, directed and randomized checks of round_timer_ctrl
module tb_round_timer_ctrl;

    localparam int CLK_HZ = 10, ROUND_SEC = 3, PAUSE_SEC = 1, LIVES = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst2, start2, tu2, res2, go2;
    logic [3:0] pos2, door2, sl2, fr2, lv2;
    logic [1:0] hit2, st2;

    logic       rst3, start3, tu3, res3, go3;
    logic [5:0] pos3, door3, fr3, lv3;
    logic [3:0] sl3;
    logic [2:0] hit3;
    logic [1:0] st3;

    round_timer_ctrl #(
        .NUM_PLAYERS(2), .CLK_HZ(CLK_HZ), .ROUND_SEC(ROUND_SEC), .PAUSE_SEC(PAUSE_SEC),
        .LIVES(LIVES), .TIME_W(4), .LIFE_W(2), .POS_W(2), .END_ON_FIRST_OUT(1)
    ) dut2 (
        .clk(clk), .reset(rst2), .start(start2), .player_pos(pos2), .correct_door(door2),
        .seconds_left(sl2), .time_up(tu2), .resume(res2), .frozen_pos(fr2), .lives(lv2),
        .hit(hit2), .game_over(go2), .state(st2)
    );

    round_timer_ctrl #(
        .NUM_PLAYERS(3), .CLK_HZ(CLK_HZ), .ROUND_SEC(ROUND_SEC), .PAUSE_SEC(PAUSE_SEC),
        .LIVES(LIVES), .TIME_W(4), .LIFE_W(2), .POS_W(2), .END_ON_FIRST_OUT(0)
    ) dut3 (
        .clk(clk), .reset(rst3), .start(start3), .player_pos(pos3), .correct_door(door3),
        .seconds_left(sl3), .time_up(tu3), .resume(res3), .frozen_pos(fr3), .lives(lv3),
        .hit(hit3), .game_over(go3), .state(st3)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] pos;
        logic [3:0] door;
        logic       scr;
        logic [1:0] hit;
        logic [3:0] lives;
        logic [1:0] st;
    } vec_t;
    vec_t tbl[3];

    logic [3:0] o_sl;
    logic       o_tu, o_res, o_go;
    logic [5:0] o_fr, o_lv;
    logic [2:0] o_hit;
    logic [1:0] o_st;

    int  ml[3];
    logic m_over;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic snap(input int which);
        if (which == 2) begin
            o_sl = sl2; o_tu = tu2; o_res = res2; o_go = go2; o_st = st2;
            o_fr = {2'b00, fr2}; o_lv = {2'b00, lv2}; o_hit = {1'b0, hit2};
        end else begin
            o_sl = sl3; o_tu = tu3; o_res = res3; o_go = go3; o_st = st3;
            o_fr = fr3; o_lv = lv3; o_hit = hit3;
        end
    endtask

    task automatic drive(input int which, input logic [5:0] pos, input logic [5:0] door);
        if (which == 2) begin
            pos2 = pos[3:0]; door2 = door[3:0];
        end else begin
            pos3 = pos; door3 = door;
        end
    endtask

    // Called on the first sample after entering PLAY; returns on the first sample after REVEAL ends.
    task automatic run_round(input int which, input logic [5:0] pos, input logic [5:0] door,
                             input logic scr, input logic [2:0] ehit, input logic [5:0] elives,
                             input logic [1:0] est);
        drive(which, pos, door);
        step(29); snap(which);
        chk("pre_tick_sl", 32'(o_sl), 32'd1);
        chk("pre_tick_time_up", 32'(o_tu), 32'd0);
        step(1); snap(which);
        chk("timeup_sl", 32'(o_sl), 32'd0);
        chk("timeup_flag", 32'(o_tu), 32'd1);
        chk("timeup_state", 32'(o_st), 32'd2);
        chk("frozen_latch", 32'(o_fr), 32'(pos));
        if (scr) drive(which, ~pos, door);
        step(9); snap(which);
        chk("reveal_hold_tu", 32'(o_tu), 32'd1);
        chk("reveal_no_resume", 32'(o_res), 32'd0);
        chk("frozen_hold", 32'(o_fr), 32'(pos));
        step(1); snap(which);
        chk("resume_pulse", 32'(o_res), 32'd1);
        chk("eval_hit", 32'(o_hit), 32'(ehit));
        chk("eval_lives", 32'(o_lv), 32'(elives));
        chk("eval_state", 32'(o_st), 32'(est));
        chk("eval_game_over", 32'(o_go), (est == 2'd3) ? 32'd1 : 32'd0);
        chk("eval_sl", 32'(o_sl), (est == 2'd3) ? 32'd0 : 32'(ROUND_SEC));
    endtask

    // Reference: one round of the game rules for the 3-player, last-survivor variant.
    task automatic play3(input logic [5:0] pos, input logic [5:0] door, input logic scr);
        logic [2:0] eh;
        logic [5:0] el;
        int alive;
        eh = '0; el = '0; alive = 0;
        for (int p = 0; p < 3; p++) begin
            if (ml[p] > 0) begin
                if (pos[p*2 +: 2] == door[p*2 +: 2]) eh[p] = 1'b1;
                else ml[p] = ml[p] - 1;
            end
            if (ml[p] > 0) alive++;
            el[p*2 +: 2] = 2'(ml[p]);
        end
        m_over = (alive <= 1);
        run_round(3, pos, door, scr, eh, el, m_over ? 2'd3 : 2'd1);
    endtask

    task automatic start3_game();
        start3 = 1'b1; step(1); start3 = 1'b0;
        chk("g3_start_state", 32'(st3), 32'd1);
        chk("g3_start_lives", 32'(lv3), 32'h2a);
        chk("g3_start_hit", 32'(hit3), 32'd0);
        for (int p = 0; p < 3; p++) ml[p] = LIVES;
        m_over = 1'b0;
    endtask

    task automatic random_round3();
        logic [5:0] pos, door;
        int pp;
        for (int p = 0; p < 3; p++) begin
            pp = $urandom_range(0, 3);
            pos[p*2 +: 2]  = 2'(pp);
            door[p*2 +: 2] = ($urandom_range(0, 1) == 1) ? 2'(pp) : 2'($urandom_range(0, 3));
        end
        play3(pos, door, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        int seen, n;
        tbl[0] = '{pos: 4'b1001, door: 4'b0001, scr: 1'b0, hit: 2'b01, lives: 4'b0110, st: 2'd1};
        tbl[1] = '{pos: 4'b0111, door: 4'b0100, scr: 1'b1, hit: 2'b10, lives: 4'b0101, st: 2'd1};
        tbl[2] = '{pos: 4'b0010, door: 4'b1110, scr: 1'b1, hit: 2'b01, lives: 4'b0001, st: 2'd3};

        rst2 = 1'b1; rst3 = 1'b1; start2 = 1'b0; start3 = 1'b0;
        pos2 = '0; door2 = '0; pos3 = '0; door3 = '0;
        step(3);
        rst2 = 1'b0; rst3 = 1'b0;
        chk("rst_state", 32'(st2), 32'd0);
        chk("rst_sl", 32'(sl2), 32'd3);
        chk("rst_lives", 32'(lv2), 32'ha);
        chk("rst_lives3", 32'(lv3), 32'h2a);
        chk("rst_flags", 32'({tu2, res2, go2}), 32'd0);
        chk("rst_frozen_hit", 32'({fr2, hit2}), 32'd0);

        // Countdown timing with both players correct.
        pos2 = 4'b1101; door2 = 4'b1101;
        start2 = 1'b1; step(1); start2 = 1'b0;
        chk("t1_state_play", 32'(st2), 32'd1);
        chk("t1_sl3", 32'(sl2), 32'd3);
        step(9);  chk("t1_sl3_late", 32'(sl2), 32'd3);
        step(1);  chk("t1_sl2", 32'(sl2), 32'd2);
        step(10); chk("t1_sl1", 32'(sl2), 32'd1);
        step(9);  chk("t1_no_timeup", 32'(tu2), 32'd0);
        step(1);  chk("t1_sl0", 32'(sl2), 32'd0);
        chk("t1_timeup", 32'(tu2), 32'd1);
        step(9);  chk("t1_no_resume", 32'(res2), 32'd0);
        step(1);  chk("t1_resume", 32'(res2), 32'd1);
        chk("t1_hit", 32'(hit2), 32'd3);
        chk("t1_lives", 32'(lv2), 32'ha);
        chk("t1_back_play", 32'({st2, sl2}), 32'h13);

        for (int i = 0; i < 3; i++)
            run_round(2, {2'b00, tbl[i].pos}, {2'b00, tbl[i].door}, tbl[i].scr,
                      {1'b0, tbl[i].hit}, {2'b00, tbl[i].lives}, tbl[i].st);

        step(25);
        chk("go_hold_lives", 32'(lv2), 32'h1);
        chk("go_hold_state", 32'({st2, go2}), 32'h7);
        chk("go_hold_hit", 32'(hit2), 32'd1);
        start2 = 1'b1; step(1); start2 = 1'b0;
        chk("restart_state", 32'(st2), 32'd1);
        chk("restart_lives", 32'(lv2), 32'ha);
        chk("restart_hit_sl", 32'({hit2, sl2}), 32'h3);

        // Reset in the middle of a reveal pause.
        step(35);
        chk("mid_reveal", 32'({st2, tu2}), 32'h5);
        rst2 = 1'b1; step(1);
        chk("midrst_state", 32'(st2), 32'd0);
        chk("midrst_tu_res", 32'({tu2, res2}), 32'd0);
        chk("midrst_lives_sl", 32'({lv2, sl2}), 32'ha3);
        rst2 = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            if (res2) seen++;
        end
        chk("midrst_no_resume", 32'(seen), 32'd0);
        chk("midrst_idle", 32'({st2, sl2}), 32'h3);

        // Three players, game ends only when at most one survivor remains.
        start3_game();
        play3({2'd1, 2'd2, 2'd3}, {2'd0, 2'd2, 2'd3}, 1'b0);
        play3({2'd1, 2'd2, 2'd3}, {2'd0, 2'd2, 2'd3}, 1'b1);
        play3({2'd1, 2'd2, 2'd3}, {2'd1, 2'd2, 2'd3}, 1'b0);
        n = 0;
        while (!m_over && n < 60) begin
            random_round3();
            n++;
        end
        if (m_over) begin
            step(25);
            chk("g3_over_hold", 32'({st3, lv3}), {24'd0, 2'd3, 6'(ml[2] * 16 + ml[1] * 4 + ml[0])});
        end

        rst3 = 1'b1; step(1); rst3 = 1'b0;
        start3_game();
        n = 0;
        while (!m_over && n < 60) begin
            random_round3();
            n++;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
